dmem_responder: RTL

//  Data-memory target for the memory stage's load/store requests: a valid/ready request port
//  in, a valid/ready response port out. It owns the data RAM (2**DMEM_POWER words of `WORD

---
 rtl/dmem_responder_if.sv | 28 ++
 rtl/dmem_responder.sv | 130 +++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage (master) and the data-memory responder (slave).
// `WORD sets the data/address width and defaults to 32 when the core does not provide it.
`ifndef WORD
`define WORD 32
`endif

interface dmem_responder_if;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [`WORD-1:0]  req_addr;
    logic [`WORD-1:0]  req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [`WORD-1:0]  resp_rdata;
    logic              resp_we;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_we, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_we, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store target with a fixed access latency.
// Optional DMEM_MISALIGN_CHECK_EN flags non-word-aligned accesses and suppresses their writes.
module dmem_responder #(
    parameter int DMEM_POWER   = 18,
    parameter int READ_LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset,
    dmem_responder_if.slave    bus
);

    localparam int DEPTH = 2 ** DMEM_POWER;
    localparam logic [2:0] CNT_INIT = (READ_LATENCY >= 2) ? 3'(READ_LATENCY - 2) : 3'd0;

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
            $error("dmem_responder: READ_LATENCY must be within 1..8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t                 r_state;
    logic [2:0]             r_cnt;
    logic                   r_we;
    logic [DMEM_POWER-1:0]  r_idx;
    logic [`WORD-1:0]       r_wdata;
    logic                   r_req_ready;
    logic                   r_resp_valid;
    logic [`WORD-1:0]       r_resp_rdata;
    logic                   r_resp_we;
    logic                   r_resp_err;

    // Not reset: RAM contents survive reset.
    logic [`WORD-1:0]       r_mem [DEPTH];

    logic                   w_accept;
    logic                   w_mis;
    logic                   w_commit;
    logic [DMEM_POWER-1:0]  w_idx;
    logic [`WORD-1:0]       w_unused_addr;

    assign w_accept      = bus.req_valid && r_req_ready;
    assign w_idx         = bus.req_addr[DMEM_POWER+1:2];
    assign w_unused_addr = bus.req_addr;

`ifdef DMEM_MISALIGN_CHECK_EN
    logic [1:0] r_lo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_lo <= 2'b00;
        else if (r_state == IDLE && w_accept)
            r_lo <= bus.req_addr[1:0];
    end

    assign w_mis = (r_lo != 2'b00);
`else
    assign w_mis = 1'b0;
`endif

    // The write happens only in the single ACCESS cycle, so a RESP stall can never re-commit.
    assign w_commit = (r_state == ACCESS) && r_we && !w_mis;

    always_ff @(posedge clk) begin
        if (w_commit)
            r_mem[r_idx] <= r_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= 3'd0;
            r_we         <= 1'b0;
            r_idx        <= '0;
            r_wdata      <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_we    <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we        <= bus.req_we;
                        r_idx       <= w_idx;
                        r_wdata     <= bus.req_wdata;
                        r_req_ready <= 1'b0;
                        if (READ_LATENCY == 1) begin
                            r_state <= ACCESS;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 3'd0)
                        r_state <= ACCESS;
                    else
                        r_cnt <= r_cnt - 3'd1;
                end
                ACCESS: begin
                    // Read-before-write: a store returns the word it overwrote.
                    r_resp_rdata <= w_mis ? '0 : r_mem[r_idx];
                    r_resp_we    <= r_we;
                    r_resp_err   <= w_mis;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_we    = r_resp_we;
    assign bus.resp_err   = r_resp_err;

endmodule
